alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Control stage directly upstream of the ACC/BREG/ALU datapath in FPGAComputer. Accepts one 8-bit
//  instruction (+8-bit immediate) per valid/ready handshake and steps it through T-states. Drives the
//  load, output-enable and ALU opcode strobes the datapath consumes, plus a PC-increment pulse.
//  Replaces manual SEL/OP/OE/PRGM stimulus with a sequenced, cycle-exact control stream.
// PARAMETERS
//  DATA_W  8  immediate / operand width
//  OP_W    3  ALU opcode width (ADD,SUB,DEC,INC,OC,BND,BOR,BXR)
//  SETTLE  1  cycles ALU_OP is held stable before ALU_OE is asserted; legal 1..7
// PORTS
//  CLK          in   1       system clock, rising edge
//  RESET        in   1       asynchronous, active-low reset
//  INSTR        in   8       [7:4] class, [2:0] ALU op; [3] reserved, ignored
//  IMM          in   DATA_W  immediate for LDA/LDB, sampled with INSTR
//  INSTR_VALID  in   1       upstream has an instruction
//  INSTR_READY  out  1       sequencer accepts this cycle
//  HLT          in   1       pause: blocks new accepts, never aborts an instruction in flight
//  IMM_OUT      out  DATA_W  latched immediate, meaningful while IMM_OE=1
//  IMM_OE       out  1       drive IMM_OUT onto the bus
//  ACC_LD       out  1       ACC loads bus this cycle
//  BREG_LD      out  1       BREG loads bus this cycle
//  ALU_OP       out  OP_W    opcode to ALU
//  ALU_OE       out  1       ALU result onto bus
//  ACC_OE       out  1       ACC onto bus
//  OUT_LD       out  1       output register loads bus
//  PC_INC       out  1       one-cycle pulse per accepted instruction
//  ILLEGAL      out  1       one-cycle pulse on undefined class
//  HALTED       out  1       HALT executed; sticky until reset
// BEHAVIOUR
//  Reset (RESET=0, async): state IDLE, all outputs 0 incl. INSTR_READY, IMM_OUT=0, ALU_OP=000.
//  INSTR_READY = (state==IDLE) & !HLT & RESET; accept = INSTR_VALID & INSTR_READY; INSTR/IMM latched.
//  States: IDLE, DECODE, EXEC (counter-driven), WB, HALTED. Accept -> DECODE next cycle.
//  DECODE (1 cycle): PC_INC=1; ILLEGAL=1 if class undefined. Next state by class:
//   0x0 NOP   -> IDLE.
//   0x1 LDA   -> WB: IMM_OE=1, ACC_LD=1 -> IDLE.
//   0x2 LDB   -> WB: IMM_OE=1, BREG_LD=1 -> IDLE.
//   0x3 ALU   -> EXEC for SETTLE cycles: ALU_OP=INSTR[2:0], ALU_OE=0; then WB: ALU_OP held,
//                ALU_OE=1, ACC_LD=1 -> IDLE. ALU_OP is the latched opcode from EXEC entry through WB
//                and retains its value afterwards (only changes on the next ALU instruction).
//   0x4 OUT   -> WB: ACC_OE=1, OUT_LD=1 -> IDLE.
//   0xF HALT  -> HALTED: HALTED=1, INSTR_READY=0 forever; only RESET exits.
//   other     -> ILLEGAL pulse, executes as NOP -> IDLE.
//  Latency accept->bus strobe: LDA/LDB/OUT 2 cycles; ALU 2+SETTLE; NOP 1; back-to-back throughput
//   = one instruction per (latency+1) cycles since READY is only high in IDLE.
//  At most one bus driver (IMM_OE, ALU_OE, ACC_OE) high in any cycle; strobes are single-cycle.
//  HLT rising mid-instruction: instruction completes, sequencer parks in IDLE with READY=0.
//  INSTR_VALID dropping after accept has no effect (instruction already latched).
//  RESET asserted mid-instruction: all strobes drop in the same cycle, no partial WB.
//  SETTLE counter counts down from SETTLE to 1; no wrap; out-of-range values are illegal to elaborate.
// STRUCTURE
//  Package alu_seq_pkg: class codes (NOP,LDA,LDB,ALU,OUT,HALT), ALU op codes ADD..BXR (000..111),
//   state encoding localparams.
//  One sub-module alu_seq_decode: combinational class -> {next_state, legal} decode.
//  FSM, SETTLE counter and latches live in alu_sequencer.
// TESTING
//  1 LDA IMM=0xAA, then LDB IMM=0x55 -> IMM_OUT=0xAA with ACC_LD 2 cycles after accept; BREG_LD
//    likewise for 0x55; PC_INC pulses twice.
//  2 ALU op ADD (INSTR=0x30), SETTLE=1 -> ALU_OP=000 for 2 cycles, ALU_OE&ACC_LD only in 2nd;
//    sweep ops SUB..BXR (0x31..0x37) with matching ALU_OP each.
//  3 SETTLE=3, ALU op BXR -> ALU_OE asserted exactly 5 cycles after accept; no bus-driver overlap.
//  4 HLT=1 while ALU op in EXEC -> WB still occurs; INSTR_READY stays 0 until HLT=0.
//  5 INSTR=0x90 -> ILLEGAL and PC_INC pulse together, no load strobes; INSTR=0xF0 -> HALTED=1,
//    INSTR_READY=0 held for 20 cycles despite INSTR_VALID=1.
//  6 RESET low during LDA WB -> ACC_LD drops asynchronously; after release first accept works normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: instruction classes, ALU opcodes,
// FSM state codes and the registered control-strobe bundle.
package alu_seq_pkg;

  localparam int unsigned CLS_W    = 4;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned ST_W     = 3;
  localparam int unsigned CNT_W    = 3;

  // Instruction classes (INSTR[7:4])
  localparam logic [CLS_W-1:0] CLS_NOP  = 4'h0;
  localparam logic [CLS_W-1:0] CLS_LDA  = 4'h1;
  localparam logic [CLS_W-1:0] CLS_LDB  = 4'h2;
  localparam logic [CLS_W-1:0] CLS_ALU  = 4'h3;
  localparam logic [CLS_W-1:0] CLS_OUT  = 4'h4;
  localparam logic [CLS_W-1:0] CLS_HALT = 4'hF;

  // ALU opcodes (INSTR[2:0])
  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] OP_DEC = 3'b010;
  localparam logic [ALU_OP_W-1:0] OP_INC = 3'b011;
  localparam logic [ALU_OP_W-1:0] OP_OC  = 3'b100;
  localparam logic [ALU_OP_W-1:0] OP_BND = 3'b101;
  localparam logic [ALU_OP_W-1:0] OP_BOR = 3'b110;
  localparam logic [ALU_OP_W-1:0] OP_BXR = 3'b111;

  // FSM state encoding
  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_DECODE = 3'd1;
  localparam logic [ST_W-1:0] ST_EXEC   = 3'd2;
  localparam logic [ST_W-1:0] ST_WB     = 3'd3;
  localparam logic [ST_W-1:0] ST_HALTED = 3'd4;

  // Registered control strobes driven to the datapath
  typedef struct packed {
    logic imm_oe;
    logic acc_ld;
    logic breg_ld;
    logic alu_oe;
    logic acc_oe;
    logic out_ld;
    logic pc_inc;
    logic illegal;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational class decode: where the FSM goes after DECODE, and whether
// the class is defined at all.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [CLS_W-1:0] cls_i,
  output logic [ST_W-1:0]  next_state_c_o,
  output logic             legal_c_o
);

  // Class -> post-DECODE state; undefined classes fall back to NOP behaviour
  always_comb begin
    next_state_c_o = ST_IDLE;
    legal_c_o      = 1'b1;
    case (cls_i)
      CLS_NOP:                   next_state_c_o = ST_IDLE;
      CLS_LDA, CLS_LDB, CLS_OUT: next_state_c_o = ST_WB;
      CLS_ALU:                   next_state_c_o = ST_EXEC;
      CLS_HALT:                  next_state_c_o = ST_HALTED;
      default: begin
        next_state_c_o = ST_IDLE;
        legal_c_o      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Control sequencer feeding the ACC/BREG/ALU datapath: accepts one
// instruction per handshake and emits a cycle-exact stream of bus strobes.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        instr_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic              hlt_i,
  output logic [DATA_W-1:0] imm_out_o,
  output logic              imm_oe_o,
  output logic              acc_ld_o,
  output logic              breg_ld_o,
  output logic [OP_W-1:0]   alu_op_o,
  output logic              alu_oe_o,
  output logic              acc_oe_o,
  output logic              out_ld_o,
  output logic              pc_inc_o,
  output logic              illegal_o,
  output logic              halted_o
);

  // Reject settle counts the down-counter cannot represent
  if ((SETTLE < 1) || (SETTLE > 7)) begin : g_settle_range
    $error("alu_sequencer: SETTLE must be in 1..7");
  end

  logic [ST_W-1:0]     state_q, state_d;
  logic [CLS_W-1:0]    cls_q, cls_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  ctrl_t               ctrl_q, ctrl_d;

  logic [CLS_W-1:0]    dec_cls;
  logic [ST_W-1:0]     dec_next;
  logic                dec_legal;
  logic                accept;
  logic                unused_instr_bit;

  // Bit 3 of the instruction is reserved
  assign unused_instr_bit = instr_i[3];

  // Ready only while idle, not paused and out of reset
  assign instr_ready_o = (state_q == ST_IDLE) & ~hlt_i & rst_n;
  assign accept        = instr_valid_i & instr_ready_o;

  // In IDLE decode the incoming class (ILLEGAL flag), otherwise the latched one
  assign dec_cls = (state_q == ST_IDLE) ? instr_i[7:4] : cls_q;

  alu_seq_decode u_decode (
    .cls_i          (dec_cls),
    .next_state_c_o (dec_next),
    .legal_c_o      (dec_legal)
  );

  // Next-state and next-strobe logic; strobes are computed for the state being entered
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    op_d     = op_q;
    imm_d    = imm_q;
    alu_op_d = alu_op_q;
    cnt_d    = cnt_q;
    ctrl_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cls_d          = instr_i[7:4];
          op_d           = instr_i[2:0];
          imm_d          = imm_i;
          state_d        = ST_DECODE;
          ctrl_d.pc_inc  = 1'b1;
          ctrl_d.illegal = ~dec_legal;
        end
      end
      ST_DECODE: begin
        state_d = dec_next;
        if (dec_next == ST_EXEC) begin
          alu_op_d = OP_W'(op_q);
          cnt_d    = CNT_W'(SETTLE);
        end else if (dec_next == ST_WB) begin
          ctrl_d.imm_oe  = (cls_q == CLS_LDA) | (cls_q == CLS_LDB);
          ctrl_d.acc_ld  = (cls_q == CLS_LDA);
          ctrl_d.breg_ld = (cls_q == CLS_LDB);
          ctrl_d.acc_oe  = (cls_q == CLS_OUT);
          ctrl_d.out_ld  = (cls_q == CLS_OUT);
        end
      end
      ST_EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d       = ST_WB;
          ctrl_d.alu_oe = 1'b1;
          ctrl_d.acc_ld = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WB:     state_d = ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    ctrl_d.halted = (state_d == ST_HALTED);
  end

  // State, latches and registered strobes; reset clears every output at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cls_q    <= '0;
      op_q     <= '0;
      imm_q    <= '0;
      alu_op_q <= '0;
      cnt_q    <= '0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      op_q     <= op_d;
      imm_q    <= imm_d;
      alu_op_q <= alu_op_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign imm_out_o = imm_q;
  assign alu_op_o  = alu_op_q;
  assign imm_oe_o  = ctrl_q.imm_oe;
  assign acc_ld_o  = ctrl_q.acc_ld;
  assign breg_ld_o = ctrl_q.breg_ld;
  assign alu_oe_o  = ctrl_q.alu_oe;
  assign acc_oe_o  = ctrl_q.acc_oe;
  assign out_ld_o  = ctrl_q.out_ld;
  assign pc_inc_o  = ctrl_q.pc_inc;
  assign illegal_o = ctrl_q.illegal;
  assign halted_o  = ctrl_q.halted;

endmodule
